// File: rtl/mul_pkg.sv
// Shared multiply-unit encodings: op select (also decoded by the control unit),
// FSM states, latched operation context and the default digit width.
package mul_pkg;

  localparam int unsigned MUL_BPC_DEFAULT = 2;
  localparam int unsigned MUL_OP_W        = 3;
  localparam int unsigned MUL_WORD_W      = 32;
  localparam int unsigned MUL_RES_W       = 64;

  localparam logic [MUL_OP_W-1:0] MUL_OP_MUL   = 3'd0;
  localparam logic [MUL_OP_W-1:0] MUL_OP_MLA   = 3'd1;
  localparam logic [MUL_OP_W-1:0] MUL_OP_UMULL = 3'd2;
  localparam logic [MUL_OP_W-1:0] MUL_OP_SMULL = 3'd3;
  localparam logic [MUL_OP_W-1:0] MUL_OP_UMLAL = 3'd4;
  localparam logic [MUL_OP_W-1:0] MUL_OP_SMLAL = 3'd5;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_FIX  = 2'd2,
    MS_DONE = 2'd3
  } mul_state_e;

  // Operation context captured at accept and consumed in FIX.
  typedef struct packed {
    logic [MUL_OP_W-1:0]  op;
    logic                 neg;
    logic [MUL_RES_W-1:0] acc;
  } mul_ctx_t;

  // Reserved encodings behave as MUL.
  function automatic logic [MUL_OP_W-1:0] mul_op_norm(input logic [MUL_OP_W-1:0] op);
    return (op > MUL_OP_SMLAL) ? MUL_OP_MUL : op;
  endfunction

  function automatic logic mul_op_signed(input logic [MUL_OP_W-1:0] op);
    return (op == MUL_OP_SMULL) || (op == MUL_OP_SMLAL);
  endfunction

  function automatic logic mul_op_short(input logic [MUL_OP_W-1:0] op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MLA);
  endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Execute-stage request/response bundle between the pipeline (master) and the multiplier (slave).
interface mul_iter_unit_if;
  import mul_pkg::*;

  logic                  start;
  logic                  kill;
  logic [MUL_OP_W-1:0]   op;
  logic [MUL_WORD_W-1:0] srca;
  logic [MUL_WORD_W-1:0] srcb;
  logic [MUL_WORD_W-1:0] srcc;
  logic [MUL_WORD_W-1:0] srcd;
  logic                  busy;
  logic                  done;
  logic [MUL_RES_W-1:0]  result;

  modport master (
    output start, kill, op, srca, srcb, srcc, srcd,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, srca, srcb, srcc, srcd,
    output busy, done, result
  );

endinterface

// File: rtl/mul_step.sv
// One iteration of shift-add multiply: sum_in + ((mcand * digit) << shift), modulo 2^64.
module mul_step
  import mul_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = MUL_BPC_DEFAULT
) (
  input  logic [MUL_WORD_W-1:0]     mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  input  logic [5:0]                shift,
  input  logic [MUL_RES_W-1:0]      sum_in,
  output logic [MUL_RES_W-1:0]      sum_next_c
);

  logic [MUL_RES_W-1:0] pp_c;

  always_comb begin
    pp_c       = (MUL_RES_W'(mcand) * MUL_RES_W'(digit)) << shift;
    sum_next_c = sum_in + pp_c;
  end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative multiply / multiply-accumulate unit for the Execute stage.
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = MUL_BPC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  mul_iter_unit_if.slave  bus
);

  localparam int unsigned ITER    = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned SHIFT_W = 6;

  mul_state_e            state_q,  state_d;
  mul_ctx_t              ctx_q,    ctx_d;
  logic [MUL_WORD_W-1:0] mcand_q,  mcand_d;
  logic [MUL_WORD_W-1:0] mplier_q, mplier_d;
  logic [MUL_RES_W-1:0]  sum_q,    sum_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [SHIFT_W-1:0]    shift_q,  shift_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic [MUL_RES_W-1:0]  result_q, result_d;

  logic                  accept_c;
  logic [MUL_OP_W-1:0]   op_in_c;
  logic                  sgn_in_c;
  logic [MUL_WORD_W-1:0] a_abs_c;
  logic [MUL_WORD_W-1:0] b_abs_c;
  logic [MUL_RES_W-1:0]  acc_in_c;
  logic [MUL_RES_W-1:0]  step_sum_c;
  logic [MUL_WORD_W-1:0] mplier_nxt_c;
  logic                  run_last_c;
  logic [MUL_RES_W-1:0]  sum_fix_c;
  logic [MUL_RES_W-1:0]  res_fix_c;

  mul_step #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .mcand      (mcand_q),
    .digit      (mplier_q[BITS_PER_CYCLE-1:0]),
    .shift      (shift_q),
    .sum_in     (sum_q),
    .sum_next_c (step_sum_c)
  );

  // Operand conditioning for the accept cycle: signed ops run on magnitudes.
  always_comb begin
    accept_c = ((state_q == MS_IDLE) || (state_q == MS_DONE)) && bus.start && !bus.kill;
    op_in_c  = mul_op_norm(bus.op);
    sgn_in_c = mul_op_signed(op_in_c);
    a_abs_c  = (sgn_in_c && bus.srca[MUL_WORD_W-1]) ? -bus.srca : bus.srca;
    b_abs_c  = (sgn_in_c && bus.srcb[MUL_WORD_W-1]) ? -bus.srcb : bus.srcb;
    unique case (op_in_c)
      MUL_OP_MLA:                 acc_in_c = {{MUL_WORD_W{1'b0}}, bus.srcc};
      MUL_OP_UMLAL, MUL_OP_SMLAL: acc_in_c = {bus.srcd, bus.srcc};
      default:                    acc_in_c = '0;
    endcase
  end

  // Iteration end and the FIX-stage sign/accumulate correction.
  always_comb begin
    mplier_nxt_c = mplier_q >> BITS_PER_CYCLE;
`ifdef MUL_EARLY_TERM_EN
    run_last_c   = (cnt_q == '0) || (mplier_nxt_c == '0);
`else
    run_last_c   = (cnt_q == '0);
`endif
    sum_fix_c    = ctx_q.neg ? -sum_q : sum_q;
    res_fix_c    = sum_fix_c + ctx_q.acc;
    if (mul_op_short(ctx_q.op)) begin
      res_fix_c[MUL_RES_W-1:MUL_WORD_W] = '0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    result_d = result_q;

    unique case (state_q)
      MS_IDLE, MS_DONE: begin
        state_d = MS_IDLE;
        if (accept_c) begin
          state_d   = MS_RUN;
          ctx_d.op  = op_in_c;
          ctx_d.neg = sgn_in_c && (bus.srca[MUL_WORD_W-1] ^ bus.srcb[MUL_WORD_W-1]);
          ctx_d.acc = acc_in_c;
          mcand_d   = a_abs_c;
          mplier_d  = b_abs_c;
          sum_d     = '0;
          cnt_d     = CNT_W'(ITER - 1);
          shift_d   = '0;
        end
      end
      MS_RUN: begin
        if (bus.kill) begin
          state_d = MS_IDLE;
        end else begin
          sum_d    = step_sum_c;
          mplier_d = mplier_nxt_c;
          shift_d  = shift_q + SHIFT_W'(BITS_PER_CYCLE);
          cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
          if (run_last_c) begin
            state_d = MS_FIX;
          end
        end
      end
      MS_FIX: begin
        if (bus.kill) begin
          state_d = MS_IDLE;
        end else begin
          result_d = res_fix_c;
          state_d  = MS_DONE;
        end
      end
      default: state_d = MS_IDLE;
    endcase

    busy_d = (state_d == MS_RUN) || (state_d == MS_FIX);
    done_d = (state_d == MS_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= MS_IDLE;
      ctx_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ctx_q    <= ctx_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Scoreboard bench for mul_iter_unit: expected result, done cycle and busy length are
// queued when an op is started and checked when done pulses.
module tb_mul_iter_unit;
  import mul_pkg::*;

  localparam int unsigned BPC  = MUL_BPC_DEFAULT;
  localparam int unsigned ITER = 32 / BPC;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
    int unsigned busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_push   = 0;
  int unsigned busy_run      = 0;
  int unsigned last_done_cyc = 0;
  logic [63:0] last_exp      = '0;

  mul_iter_unit_if bus();

  mul_iter_unit dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
    logic [63:0] ua, ub, sa, sb, p;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd1:    begin p = ua * ub + {32'b0, c}; p = {32'b0, p[31:0]}; end
      3'd2:    p = ua * ub;
      3'd3:    p = $signed(sa) * $signed(sb);
      3'd4:    p = ua * ub + {d, c};
      3'd5:    p = $signed(sa) * $signed(sb) + {d, c};
      default: begin p = ua * ub; p = {32'b0, p[31:0]}; end
    endcase
    return p;
  endfunction

  // Number of RUN cycles the op should take.
  function automatic int unsigned run_cycles(input logic [2:0] op, input logic [31:0] b);
    logic [31:0] babs;
    logic [63:0] bb;
    int unsigned n;
    babs = ((op == 3'd3 || op == 3'd5) && b[31]) ? -b : b;
    bb   = 64'(babs);
    n    = 1;
    while (n < ITER && (bb >> (n * BPC)) != 0) n++;
    return EARLY ? n : ITER;
  endfunction

  // Called at a negedge; the following posedge samples start.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d,
                       input bit push, input logic [63:0] exp_res);
    exp_t e;
    int unsigned k;
    bus.op   = op;
    bus.srca = a;
    bus.srcb = b;
    bus.srcc = c;
    bus.srcd = d;
    bus.start = 1'b1;
    if (push) begin
      k      = run_cycles(op, b);
      e.res  = exp_res;
      e.cyc  = cyc + 2 + k;
      e.busy = k + 1;
      exp_q.push_back(e);
      n_push++;
      last_exp = exp_res;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.srca  = $urandom;
    bus.srcb  = $urandom;
    bus.srcc  = $urandom;
    bus.srcd  = $urandom;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Done monitor and scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      n_done++;
      last_done_cyc = cyc;
      check_eq("busy_with_done", 64'(bus.busy), 64'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("result", bus.result, e.res);
        check_eq("latency", 64'(cyc), 64'(e.cyc));
        check_eq("busy_cycles", 64'(busy_run), 64'(e.busy));
      end
      busy_run = 0;
    end else if (bus.busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    int unsigned t1;
    int t;
    logic [2:0]  op;
    logic [31:0] a, b, c, d;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = '0;
    bus.srca  = '0;
    bus.srcb  = '0;
    bus.srcc  = '0;
    bus.srcd  = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 64'(bus.busy), 64'd0);
    check_eq("reset_done", 64'(bus.done), 64'd0);
    check_eq("reset_result", bus.result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    drive(MUL_OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 64'hFFFF_FFFE_0000_0001);
    wait_drain();
    drive(MUL_OP_SMULL, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_drain();
    drive(MUL_OP_SMULL, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b1, 64'h4000_0000_0000_0000);
    wait_drain();
    drive(MUL_OP_UMLAL, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b1, 64'h0000_0001_0000_0005);
    wait_drain();
    drive(MUL_OP_MLA, 32'd5, 32'd7, 32'd100, 32'hDEAD_BEEF, 1'b1, 64'h0000_0000_0000_0087);
    wait_drain();
    drive(3'd6, 32'd3, 32'd5, 32'd9, 32'd9, 1'b1, 64'd15);
    wait_drain();
    drive(MUL_OP_SMLAL, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b1, 64'd0);
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      c  = $urandom;
      d  = $urandom;
      drive(op, a, b, c, d, 1'b1, model(op, a, b, c, d));
      wait_drain();
    end

    // Back-to-back: start presented in the DONE cycle.
    drive(MUL_OP_MUL, 32'd6, 32'd7, 0, 0, 1'b1, 64'd42);
    t = 0;
    while (!bus.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("b2b_first_done", 64'(bus.done), 64'd1);
    t1 = cyc;
    drive(MUL_OP_MUL, 32'd4, 32'd4, 0, 0, 1'b1, 64'd16);
    wait_drain();
    check_eq("b2b_spacing", 64'(last_done_cyc - t1), 64'(run_cycles(MUL_OP_MUL, 32'd4) + 2));

    // start while busy must be ignored.
    a = $urandom;
    b = $urandom | 32'h8000_0000;
    drive(MUL_OP_UMULL, a, b, 0, 0, 1'b1, model(MUL_OP_UMULL, a, b, 0, 0));
    repeat (4) @(negedge clk);
    bus.op    = MUL_OP_MUL;
    bus.srca  = 32'd1;
    bus.srcb  = 32'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (25) @(negedge clk);

    // kill in RUN cycle 5.
    drive(MUL_OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, '0);
    repeat (4) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    check_eq("kill_busy", 64'(bus.busy), 64'd0);
    check_eq("kill_done", 64'(bus.done), 64'd0);
    check_eq("kill_result", bus.result, last_exp);
    repeat (25) @(negedge clk);
    check_eq("kill_result_hold", bus.result, last_exp);

    // reset in RUN cycle 8.
    drive(MUL_OP_UMULL, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 1'b0, '0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_result", bus.result, 64'd0);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // Short multiplier latency.
    t0 = cyc;
    drive(MUL_OP_MUL, 32'd9, 32'd1, 0, 0, 1'b1, 64'd9);
    wait_drain();
    check_eq("mul9_latency", 64'(last_done_cyc - t0), EARLY ? 64'd3 : 64'd18);

    repeat (5) @(negedge clk);
    check_eq("done_count", 64'(n_done), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
